imuldiv_mul_arbiter: RTL and testbench
======================================

Name: imuldiv_mul_arbiter

Overview:
Two-requester round-robin arbiter that shares a single iterative multiplier between two clients, e.g. two issue ports or a core and a coprocessor. The multiplier accepts one request and then returns one response, so only one transaction may be outstanding at a time. The block captures the winning request, issues it to the multiplier, tracks the owner, and routes the response back to that owner only. It sits between the clients and the multiplier's val/rdy request and response interfaces.

Parameters:
DW, 32, operand width; the result width is 2*DW.

Ports:
clk  input  1  clock
reset  input  1  reset
req0_msg_a  input  DW  client 0 operand A
req0_msg_b  input  DW  client 0 operand B
req0_val  input  1  client 0 request valid
req0_rdy  output  1  client 0 request ready
resp0_msg  output  2*DW  client 0 result
resp0_val  output  1  client 0 response valid
resp0_rdy  input  1  client 0 response ready
req1_msg_a, req1_msg_b, req1_val, req1_rdy, resp1_msg, resp1_val, resp1_rdy: same as client 0, for client 1
mulreq_msg_a  output  DW  operand A to multiplier
mulreq_msg_b  output  DW  operand B to multiplier
mulreq_val  output  1  request valid to multiplier
mulreq_rdy  input  1  multiplier ready
mulresp_msg_result  input  2*DW  multiplier result
mulresp_val  input  1  multiplier response valid
mulresp_rdy  output  1  ready to multiplier
busy  output  1  a transaction is in flight (state != IDLE)

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- Reset state: state=IDLE, prio=0, owner=0, operand registers 0. Immediately after reset all outputs are 0: rdy/val outputs, busy, and the message outputs.
- States: IDLE, ISSUE, WAIT. Encoding 2'b11 is illegal and goes to IDLE on the next cycle with all outputs deasserted.
- Winner in IDLE:
  - If only one reqN_val is high, that client wins.
  - If both are high, client prio wins.
  - If neither is high, there is no winner.
- IDLE:
  - reqN_rdy=1 only for the winner, so rdy depends combinationally on both vals and prio.
  - On winner fire: latch msg_a/msg_b into the operand registers, owner<=winner, prio<=~winner, go to ISSUE.
  - mulreq_val=0, mulresp_rdy=0, respN_val=0.
- ISSUE:
  - mulreq_val=1 and mulreq_msg_* = operand registers.
  - When mulreq_rdy=1: go to WAIT.
  - Both reqN_rdy=0.
- WAIT:
  - resp[owner]_val = mulresp_val and resp[owner]_msg = mulresp_msg_result.
  - mulresp_rdy = resp[owner]_rdy.
  - The non-owner respN_val=0 and its respN_msg=0.
  - On mulresp_val & mulresp_rdy: go to IDLE.
- Message outputs (respN_msg, mulreq_msg_*) are 0 whenever their val is 0.
- Latency:
  - Request fire at cycle t gives mulreq_val at t+1.
  - The response path is combinational pass-through (0 cycles).
  - The next request can be accepted in the cycle after response fire (IDLE only).
- Fairness: under continuous contention, grants alternate 0,1,0,1. A lone requester wins every time, and prio is then set to the other client.
- Owner backpressure: if resp[owner]_rdy=0, the response is held and the arbiter stays in WAIT indefinitely. The other client is stalled (reqN_rdy=0).
- A mulresp_val arriving outside WAIT is ignored (mulresp_rdy=0); this is a protocol error for the bench to flag.
- Reset mid-transaction: immediate return to IDLE. The in-flight transaction is dropped and no response is delivered. The multiplier shares the same reset.
- Data is passed through unmodified; no arithmetic is done in this block.

Test Plan:
- Single client: req0 a=3, b=-5 (0xFFFFFFFB) -> mulreq_val the cycle after fire with a=3, b=0xFFFFFFFB; resp0 receives 0xFFFFFFFFFFFFFFF1; resp1_val stays 0 throughout.
- Contention after reset: both valid, req0 a=2/b=7, req1 a=-4/b=-6 -> client 0 granted first (resp0=14), then client 1 (resp1=24); req1_rdy=0 until the arbiter returns to IDLE.
- Continuous contention over 6 transactions -> grant order 0,1,0,1,0,1; prio toggles after each grant.
- Owner backpressure: resp1_rdy held low for 10 cycles after mulresp_val -> resp1_val stays high with the result stable; mulresp_rdy=0; req0_rdy=0; completes on the cycle resp1_rdy rises.
- Lone requester repeats: req1 issues 3 back-to-back requests (a=1,2,3, b=0x80000000) -> each granted in turn, with results 0xFFFFFFFF80000000, 0xFFFFFFFF00000000, 0xFFFFFFFE80000000.
- Reset asserted during WAIT -> next cycle all rdy/val outputs are 0, busy=0, prio=0; a fresh req1 request is then granted normally.

Source files
------------

// File: rtl/imuldiv_mul_arbiter.sv
`default_nettype none
// ============================================================================
// imuldiv_mul_arbiter
//   Round-robin arbiter that lets two clients share one iterative multiplier,
//   with a single transaction in flight at a time.
//   Revision: 1.0
// ============================================================================
module imuldiv_mul_arbiter #(
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            reset,

   input  logic [DW-1:0]   req0_msg_a,
   input  logic [DW-1:0]   req0_msg_b,
   input  logic            req0_val,
   output logic            req0_rdy,
   output logic [2*DW-1:0] resp0_msg,
   output logic            resp0_val,
   input  logic            resp0_rdy,

   input  logic [DW-1:0]   req1_msg_a,
   input  logic [DW-1:0]   req1_msg_b,
   input  logic            req1_val,
   output logic            req1_rdy,
   output logic [2*DW-1:0] resp1_msg,
   output logic            resp1_val,
   input  logic            resp1_rdy,

   output logic [DW-1:0]   mulreq_msg_a,
   output logic [DW-1:0]   mulreq_msg_b,
   output logic            mulreq_val,
   input  logic            mulreq_rdy,
   input  logic [2*DW-1:0] mulresp_msg_result,
   input  logic            mulresp_val,
   output logic            mulresp_rdy,

   output logic            busy
);

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_ISSUE = 2'b01;
   localparam logic [1:0] ST_WAIT  = 2'b10;

   logic [1:0]    state_q, state_d;
   logic          prio_q,  prio_d;
   logic          owner_q, owner_d;
   logic [DW-1:0] opa_q,   opa_d;
   logic [DW-1:0] opb_q,   opb_d;

   logic          any_val;
   logic          winner;

   always_comb begin
      any_val = req0_val | req1_val;
      // With both requesting the priority client wins, otherwise whoever asks.
      winner  = (req0_val & req1_val) ? prio_q : req1_val;

      state_d = state_q;
      prio_d  = prio_q;
      owner_d = owner_q;
      opa_d   = opa_q;
      opb_d   = opb_q;

      req0_rdy     = 1'b0;
      req1_rdy     = 1'b0;
      resp0_val    = 1'b0;
      resp0_msg    = '0;
      resp1_val    = 1'b0;
      resp1_msg    = '0;
      mulreq_val   = 1'b0;
      mulreq_msg_a = '0;
      mulreq_msg_b = '0;
      mulresp_rdy  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            req0_rdy = any_val & ~winner;
            req1_rdy = any_val &  winner;
            if (any_val) begin
               opa_d   = winner ? req1_msg_a : req0_msg_a;
               opb_d   = winner ? req1_msg_b : req0_msg_b;
               owner_d = winner;
               prio_d  = ~winner;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            mulreq_val   = 1'b1;
            mulreq_msg_a = opa_q;
            mulreq_msg_b = opb_q;
            if (mulreq_rdy) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Response is a straight pass-through to the owner only.
            mulresp_rdy = owner_q ? resp1_rdy : resp0_rdy;
            if (mulresp_val) begin
               if (owner_q) begin
                  resp1_val = 1'b1;
                  resp1_msg = mulresp_msg_result;
               end else begin
                  resp0_val = 1'b1;
                  resp0_msg = mulresp_msg_result;
               end
            end
            if (mulresp_val && mulresp_rdy) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         prio_q  <= 1'b0;
         owner_q <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         owner_q <= owner_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imuldiv_mul_arbiter.sv
`default_nettype none
// tb_imuldiv_mul_arbiter: directed and randomized checks of the shared-multiplier
// arbiter against a transaction-level round-robin model and a signed multiplier.
module tb_imuldiv_mul_arbiter;
   localparam int DW = 32;

   typedef struct packed { logic [DW-1:0] a; logic [DW-1:0] b; } op_t;
   typedef struct packed { logic c; logic [DW-1:0] a; logic [DW-1:0] b; } gnt_t;
   typedef struct packed { logic c; logic [2*DW-1:0] m; } rsp_t;

   logic            clk, reset;
   logic [DW-1:0]   req0_msg_a, req0_msg_b, req1_msg_a, req1_msg_b;
   logic            req0_val, req0_rdy, req1_val, req1_rdy;
   logic [2*DW-1:0] resp0_msg, resp1_msg;
   logic            resp0_val, resp0_rdy, resp1_val, resp1_rdy;
   logic [DW-1:0]   mulreq_msg_a, mulreq_msg_b;
   logic            mulreq_val, mulreq_rdy;
   logic [2*DW-1:0] mulresp_msg_result;
   logic            mulresp_val, mulresp_rdy;
   logic            busy;

   int   vectors = 0;
   int   miscompares = 0;
   op_t  q0[$], q1[$], mq0[$], mq1[$];
   gnt_t obs_g[$], exp_g[$];
   rsp_t obs_r[$], exp_r[$];
   logic ref_prio = 1'b0;
   bit   bp0 = 0, bp1 = 0, c_rand = 0, m_rand = 0, stray = 0;
   int   m_lat = 1;
   int   inv_err = 0;
   int   r1_seen = 0;

   imuldiv_mul_arbiter #(.DW(DW)) dut (
      .clk(clk), .reset(reset),
      .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b), .req0_val(req0_val), .req0_rdy(req0_rdy),
      .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
      .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b), .req1_val(req1_val), .req1_rdy(req1_rdy),
      .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
      .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b), .mulreq_val(mulreq_val),
      .mulreq_rdy(mulreq_rdy), .mulresp_msg_result(mulresp_msg_result),
      .mulresp_val(mulresp_val), .mulresp_rdy(mulresp_rdy), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [2*DW-1:0] prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic signed [2*DW-1:0] sa, sb;
      sa = {{DW{a[DW-1]}}, a};
      sb = {{DW{b[DW-1]}}, b};
      return sa * sb;
   endfunction

   // Environment: clients, a multiplier with variable latency, and a monitor.
   // Samples one time unit before each rising edge, drives one after it.
   initial begin : env
      bit f0, f1, rf, pf, rs, m_busy, m_pend;
      int m_cnt;
      op_t sop;
      logic [2*DW-1:0] m_res;
      m_busy = 0; m_pend = 0; m_cnt = 0; m_res = '0; sop = '0;
      req0_val = 0; req0_msg_a = '0; req0_msg_b = '0; resp0_rdy = 0;
      req1_val = 0; req1_msg_a = '0; req1_msg_b = '0; resp1_rdy = 0;
      mulreq_rdy = 0; mulresp_val = 0; mulresp_msg_result = '0;
      forever begin
         @(negedge clk); #4;
         rs = reset;
         f0 = !rs && req0_val && req0_rdy;
         f1 = !rs && req1_val && req1_rdy;
         rf = !rs && mulreq_val && mulreq_rdy;
         pf = !rs && mulresp_val && mulresp_rdy;
         if (f0) obs_g.push_back({1'b0, req0_msg_a, req0_msg_b});
         if (f1) obs_g.push_back({1'b1, req1_msg_a, req1_msg_b});
         if (rf) sop = {mulreq_msg_a, mulreq_msg_b};
         if (!rs && resp0_val && resp0_rdy) obs_r.push_back({1'b0, resp0_msg});
         if (!rs && resp1_val && resp1_rdy) obs_r.push_back({1'b1, resp1_msg});
         if (resp1_val) r1_seen++;
         if (busy && (req0_rdy || req1_rdy)) inv_err++;
         if (resp0_val && resp1_val) inv_err++;
         if ((!resp0_val && resp0_msg != '0) || (!resp1_val && resp1_msg != '0)) inv_err++;
         if (!mulreq_val && (mulreq_msg_a != '0 || mulreq_msg_b != '0)) inv_err++;
         if (!busy && mulresp_rdy) inv_err++;
         @(posedge clk); #1;
         if (f0 && q0.size() != 0) q0.delete(0);
         if (f1 && q1.size() != 0) q1.delete(0);
         if (rs) begin
            m_busy = 0; m_pend = 0;
         end else begin
            if (pf) begin m_busy = 0; m_pend = 0; end
            if (rf) begin
               m_busy = 1;
               m_res  = prod(sop.a, sop.b);
               m_cnt  = m_rand ? int'($urandom_range(0, 3)) : m_lat;
            end
            if (m_busy && !m_pend) begin
               if (m_cnt == 0) m_pend = 1;
               else m_cnt--;
            end
         end
         mulresp_val        = m_pend || stray;
         mulresp_msg_result = m_pend ? m_res : (stray ? 64'hDEAD_BEEF_0000_0001 : '0);
         mulreq_rdy         = !m_busy && !rs && (!m_rand || $urandom_range(0, 1) == 1);
         req0_val = (q0.size() != 0);
         {req0_msg_a, req0_msg_b} = (q0.size() != 0) ? q0[0] : '0;
         req1_val = (q1.size() != 0);
         {req1_msg_a, req1_msg_b} = (q1.size() != 0) ? q1[0] : '0;
         resp0_rdy = !bp0 && (!c_rand || $urandom_range(0, 1) == 1);
         resp1_rdy = !bp1 && (!c_rand || $urandom_range(0, 1) == 1);
      end
   end

   task automatic push(input logic c, input logic [DW-1:0] a, input logic [DW-1:0] b);
      op_t op;
      op = {a, b};
      if (c) begin q1.push_back(op); mq1.push_back(op); end
      else   begin q0.push_back(op); mq0.push_back(op); end
   endtask

   // Round-robin reference: a lone requester wins, a tie goes to the priority
   // client, and priority then passes to the loser.
   task automatic build_expected();
      logic w;
      op_t  op;
      while (mq0.size() != 0 || mq1.size() != 0) begin
         w = (mq0.size() != 0 && mq1.size() != 0) ? ref_prio : (mq1.size() != 0);
         if (w) begin op = mq1[0]; mq1.delete(0); end
         else   begin op = mq0[0]; mq0.delete(0); end
         exp_g.push_back({w, op.a, op.b});
         exp_r.push_back({w, prod(op.a, op.b)});
         ref_prio = ~w;
      end
   endtask

   task automatic start();
      @(negedge clk);
      obs_g.delete(); obs_r.delete(); exp_g.delete(); exp_r.delete();
      mq0.delete(); mq1.delete();
      r1_seen = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      q0.delete(); q1.delete();
      ref_prio = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_done(input int n, output bit ok);
      ok = 0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         if (obs_r.size() >= n && q0.size() == 0 && q1.size() == 0 && !busy) ok = 1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({req0_rdy, req1_rdy, resp0_val, resp1_val, mulreq_val, mulresp_rdy, busy} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_held_ctl got=%b exp=0000000", {req0_rdy, req1_rdy, resp0_val, resp1_val, mulreq_val, mulresp_rdy, busy});
      end
      reset = 1'b0;
      ref_prio = 1'b0;
      @(posedge clk); #2;
      vectors++;
      if ({req0_rdy, req1_rdy, resp0_val, resp1_val, mulreq_val, mulresp_rdy, busy} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_ctl got=%b exp=0000000", {req0_rdy, req1_rdy, resp0_val, resp1_val, mulreq_val, mulresp_rdy, busy});
      end
      vectors++;
      if ({resp0_msg, resp1_msg, mulreq_msg_a, mulreq_msg_b} !== '0) begin
         miscompares++;
         $display("FAIL reset_msgs got=%h exp=0", {resp0_msg, resp1_msg, mulreq_msg_a, mulreq_msg_b});
      end
   endtask

   task automatic test_single();
      bit ok;
      start();
      push(1'b0, 32'd3, 32'hFFFF_FFFB);
      build_expected();
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk); #4;
         if (req0_val && req0_rdy) ok = 1;
      end
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL single_grant got=no_fire exp=fire"); end
      @(posedge clk); #2;
      vectors++;
      if ({mulreq_val, mulreq_msg_a, mulreq_msg_b, busy} !== {1'b1, 32'd3, 32'hFFFF_FFFB, 1'b1}) begin
         miscompares++;
         $display("FAIL single_issue got val=%b a=%h b=%h busy=%b exp val=1 a=00000003 b=fffffffb busy=1", mulreq_val, mulreq_msg_a, mulreq_msg_b, busy);
      end
      wait_done(1, ok);
      vectors++;
      if (!ok || obs_r.size() != 1 || obs_r[0] !== {1'b0, 64'hFFFF_FFFF_FFFF_FFF1} || obs_r[0] !== exp_r[0]) begin
         miscompares++;
         $display("FAIL single_resp got=%h n=%0d exp=%h", obs_r[0], obs_r.size(), {1'b0, 64'hFFFF_FFFF_FFFF_FFF1});
      end
      vectors++;
      if (r1_seen != 0) begin miscompares++; $display("FAIL single_resp1_quiet got=%0d exp=0", r1_seen); end
   endtask

   task automatic test_contention();
      bit ok;
      int inv0;
      do_reset();
      start();
      inv0 = inv_err;
      push(1'b0, 32'd2, 32'd7);
      push(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFA);
      build_expected();
      wait_done(2, ok);
      vectors++;
      if (!ok || obs_r.size() != 2 || obs_r[0] !== {1'b0, 64'd14} || obs_r[1] !== {1'b1, 64'd24}) begin
         miscompares++;
         $display("FAIL contention_order got=%h,%h exp=%h,%h", obs_r[0], obs_r[1], {1'b0, 64'd14}, {1'b1, 64'd24});
      end
      foreach (exp_r[i]) begin
         vectors++;
         if (i >= obs_r.size() || obs_g[i] !== exp_g[i] || obs_r[i] !== exp_r[i]) begin
            miscompares++;
            $display("FAIL contention_txn%0d got grant=%h resp=%h exp grant=%h resp=%h", i, obs_g[i], obs_r[i], exp_g[i], exp_r[i]);
         end
      end
      vectors++;
      if (inv_err != inv0) begin miscompares++; $display("FAIL contention_rdy_while_busy got=%0d exp=0", inv_err - inv0); end
   endtask

   task automatic test_fairness();
      bit ok;
      start();
      for (int k = 0; k < 3; k++) begin
         push(1'b0, $urandom, $urandom);
         push(1'b1, $urandom, $urandom);
      end
      build_expected();
      wait_done(6, ok);
      vectors++;
      if (!ok || obs_r.size() != 6) begin miscompares++; $display("FAIL fair_count got=%0d exp=6", obs_r.size()); end
      foreach (exp_r[i]) begin
         vectors++;
         if (i >= obs_r.size() || obs_g[i] !== exp_g[i] || obs_r[i] !== exp_r[i] ||
             (i > 0 && obs_g[i].c === obs_g[i-1].c)) begin
            miscompares++;
            $display("FAIL fair_txn%0d got grant=%h resp=%h exp grant=%h resp=%h", i, obs_g[i], obs_r[i], exp_g[i], exp_r[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [2*DW-1:0] res;
      logic [DW-1:0] a, b;
      start();
      bp1 = 1;
      a = $urandom; b = $urandom;
      res = prod(a, b);
      push(1'b1, a, b);
      build_expected();
      ok = 0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         if (resp1_val) ok = 1;
      end
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL bp_resp_arrive got=no_val exp=val"); end
      push(1'b0, $urandom, $urandom);
      build_expected();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vectors++;
         if ({resp1_val, resp1_msg, mulresp_rdy, req0_rdy} !== {1'b1, res, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL bp_hold%0d got val=%b msg=%h mrdy=%b rdy0=%b exp val=1 msg=%h mrdy=0 rdy0=0", i, resp1_val, resp1_msg, mulresp_rdy, req0_rdy, res);
         end
      end
      bp1 = 0;
      @(posedge clk); #2;
      vectors++;
      if (obs_r.size() != 0 || resp1_val !== 1'b1) begin
         miscompares++; $display("FAIL bp_before_rise got n=%0d val=%b exp n=0 val=1", obs_r.size(), resp1_val);
      end
      @(posedge clk); #2;
      vectors++;
      if (obs_r.size() != 1 || busy !== 1'b0) begin
         miscompares++; $display("FAIL bp_release got n=%0d busy=%b exp n=1 busy=0", obs_r.size(), busy);
      end
      wait_done(2, ok);
      foreach (exp_r[i]) begin
         vectors++;
         if (!ok || i >= obs_r.size() || obs_g[i] !== exp_g[i] || obs_r[i] !== exp_r[i]) begin
            miscompares++;
            $display("FAIL bp_txn%0d got grant=%h resp=%h exp grant=%h resp=%h", i, obs_g[i], obs_r[i], exp_g[i], exp_r[i]);
         end
      end
   endtask

   task automatic test_lone_repeat();
      bit ok;
      logic [2*DW-1:0] spec_r [3];
      spec_r[0] = 64'hFFFF_FFFF_8000_0000;
      spec_r[1] = 64'hFFFF_FFFF_0000_0000;
      spec_r[2] = 64'hFFFF_FFFE_8000_0000;
      start();
      for (int k = 1; k <= 3; k++) push(1'b1, k, 32'h8000_0000);
      build_expected();
      wait_done(3, ok);
      foreach (exp_r[i]) begin
         vectors++;
         if (!ok || i >= obs_r.size() || obs_g[i] !== exp_g[i] || obs_r[i] !== exp_r[i] || obs_r[i].m !== spec_r[i]) begin
            miscompares++;
            $display("FAIL lone_txn%0d got grant=%h resp=%h exp grant=%h resp=%h", i, obs_g[i], obs_r[i], exp_g[i], {1'b1, spec_r[i]});
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      start();
      bp0 = 1;
      push(1'b0, $urandom, $urandom);
      ok = 0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         if (resp0_val) ok = 1;
      end
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL rstmid_wait got=no_val exp=val"); end
      reset = 1'b1;
      q0.delete(); q1.delete();
      #1;
      vectors++;
      if ({req0_rdy, req1_rdy, resp0_val, resp1_val, mulreq_val, mulresp_rdy, busy} !== 7'b0) begin
         miscompares++;
         $display("FAIL rstmid_immediate got=%b exp=0000000", {req0_rdy, req1_rdy, resp0_val, resp1_val, mulreq_val, mulresp_rdy, busy});
      end
      @(posedge clk); #2;
      vectors++;
      if ({req0_rdy, req1_rdy, resp0_val, resp1_val, mulreq_val, mulresp_rdy, busy} !== 7'b0) begin
         miscompares++;
         $display("FAIL rstmid_next got=%b exp=0000000", {req0_rdy, req1_rdy, resp0_val, resp1_val, mulreq_val, mulresp_rdy, busy});
      end
      @(negedge clk);
      reset = 1'b0;
      bp0 = 0;
      ref_prio = 1'b0;
      start();
      push(1'b1, $urandom, $urandom);
      push(1'b1, $urandom, $urandom);
      build_expected();
      wait_done(2, ok);
      vectors++;
      if (!ok || obs_r.size() != 2) begin miscompares++; $display("FAIL rstmid_count got=%0d exp=2", obs_r.size()); end
      foreach (exp_r[i]) begin
         vectors++;
         if (i >= obs_r.size() || obs_g[i] !== exp_g[i] || obs_r[i] !== exp_r[i]) begin
            miscompares++;
            $display("FAIL rstmid_txn%0d got grant=%h resp=%h exp grant=%h resp=%h", i, obs_g[i], obs_r[i], exp_g[i], exp_r[i]);
         end
      end
   endtask

   task automatic test_stray();
      @(negedge clk);
      stray = 1;
      @(posedge clk); #2;
      vectors++;
      if ({mulresp_val, mulresp_rdy, resp0_val, resp1_val, busy} !== 5'b10000) begin
         miscompares++;
         $display("FAIL stray_resp got mval=%b mrdy=%b v0=%b v1=%b busy=%b exp 1 0 0 0 0", mulresp_val, mulresp_rdy, resp0_val, resp1_val, busy);
      end
      @(negedge clk);
      stray = 0;
   endtask

   task automatic test_random();
      bit ok;
      int n;
      c_rand = 1;
      m_rand = 1;
      for (int r = 0; r < 4; r++) begin
         start();
         n = $urandom_range(4, 10);
         for (int k = 0; k < n; k++) push(1'($urandom_range(0, 1)), $urandom, $urandom);
         build_expected();
         wait_done(n, ok);
         vectors++;
         if (!ok || obs_r.size() != n) begin miscompares++; $display("FAIL rand%0d_count got=%0d exp=%0d", r, obs_r.size(), n); end
         foreach (exp_r[i]) begin
            vectors++;
            if (i >= obs_r.size() || obs_g[i] !== exp_g[i] || obs_r[i] !== exp_r[i]) begin
               miscompares++;
               $display("FAIL rand%0d_txn%0d got grant=%h resp=%h exp grant=%h resp=%h", r, i, obs_g[i], obs_r[i], exp_g[i], exp_r[i]);
            end
         end
      end
      c_rand = 0;
      m_rand = 0;
      vectors++;
      if (inv_err != 0) begin miscompares++; $display("FAIL protocol_invariants got=%0d exp=0", inv_err); end
   endtask

   initial begin
      reset = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_backpressure();
      test_lone_repeat();
      test_reset_mid();
      test_stray();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
